sr_cmd_driver: RTL and testbench

SR_CMD_DRIVER -- requirements
Module: sr_cmd_driver

---
 rtl/sr_cmd_driver.sv | 107 ++++++++++
 tb/tb_sr_cmd_driver.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_driver.sv
// Pulse driver for a downstream SR latch: issues a timed set or reset pulse,
// lets the latch settle, then checks q/qbar feedback and reports done/err.
//
// state | meaning
// IDLE  | ready for a command; hold/illegal ops complete here in one cycle
// DRIVE | s or r held high for PULSE_W cycles
// GAP   | s=r=0 settle time (GAP_W-1 cycles; skipped when GAP_W is 1)
// CHECK | last settle cycle; feedback sampled at its closing edge
module sr_cmd_driver #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       done,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP, CHECK} state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LD   = 4'((GAP_W > 1) ? (GAP_W - 2) : 0);

  state_t     state;
  logic [3:0] cnt;
  logic       exp_q;
  logic       fb_ok;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // Unknown feedback leaves fb_ok unknown, which falls to the error branch below.
  assign fb_ok     = (q_fb == exp_q) && (qbar_fb == ~q_fb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      exp_q   <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      s    <= 1'b0;
      r    <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              2'b00: done <= 1'b1;
              2'b11: begin
                done    <= 1'b1;
                err     <= 1'b1;
                err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
              end
              default: begin
                state <= DRIVE;
                cnt   <= PULSE_LD;
                exp_q <= cmd_op[1];
                s     <= cmd_op[1];
                r     <= ~cmd_op[1];
              end
            endcase
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) begin
            state <= (GAP_W > 1) ? GAP : CHECK;
            cnt   <= GAP_LD;
          end else begin
            cnt <= cnt - 4'd1;
            s   <= exp_q;
            r   <= ~exp_q;
          end
        end
        GAP: begin
          if (cnt == 4'd0) state <= CHECK;
          else             cnt   <= cnt - 4'd1;
        end
        CHECK: begin
          state <= IDLE;
          done  <= 1'b1;
          if (fb_ok) begin
            err <= 1'b0;
          end else begin
            err     <= 1'b1;
            err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Scoreboard bench for sr_cmd_driver: each accepted command pushes its expected
// completion cycle, err and err_cnt; a negedge monitor pops on every done.
module tb_sr_cmd_driver;
  localparam int PW  = 2;
  localparam int GW  = 1;
  localparam int LAT = PW + GW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       s, r;
  logic       q_fb = 1'b0;
  logic       qbar_fb = 1'b1;
  logic       done, err;
  logic [7:0] err_cnt;
  logic       busy;

  sr_cmd_driver #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
    .done(done), .err(err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    bit         e;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int exp_cnt = 0;
  int accepts = 0, dones = 0;

  // Called before the accepting edge, so that edge is cyc+1.
  task automatic push(input logic [1:0] op, input logic q, input logic qb);
    exp_t x;
    bit   f;
    logic e;
    e = op[1];
    if (op == 2'b00) begin
      f = 1'b0; x.at = cyc + 1;
    end else if (op == 2'b11) begin
      f = 1'b1; x.at = cyc + 1;
    end else begin
      f = !((q === e) && (qb === ~q));
      x.at = cyc + 1 + LAT;
    end
    if (f && exp_cnt < 255) exp_cnt++;
    x.e   = f;
    x.cnt = 8'(exp_cnt);
    sb.push_back(x);
    accepts++;
  endtask

  task automatic issue(input logic [1:0] op, input logic q, input logic qb);
    cmd_op = op; q_fb = q; qbar_fb = qb; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end else begin
      push(op, q, qb);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({s, r, done, err, busy, cmd_ready} !== 6'b000001 || err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_hold: s r done err busy ready=%b%b%b%b%b%b cnt=%0d required 000001 cnt=0",
               s, r, done, err, busy, cmd_ready, err_cnt);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    sb.delete(); exp_cnt = 0; accepts = 0; dones = 0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      total++;
      if ((s & r) !== 1'b0) begin
        bad++; $display("FAIL s_r_overlap: s=%b r=%b required not both 1", s, r);
      end
      total++;
      if (cmd_ready !== ~busy) begin
        bad++; $display("FAIL ready_busy: ready=%b busy=%b required ready=~busy", cmd_ready, busy);
      end
      if (err === 1'b1 && done !== 1'b1) begin
        total++; bad++;
        $display("FAIL err_without_done: err=%b done=%b required done with err", err, done);
      end
      if (done === 1'b1) begin
        dones++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL unexpected_done: done=1 at cycle %0d required none pending", cyc);
        end else begin
          x = sb.pop_front();
          if (cyc !== x.at || err !== x.e || err_cnt !== x.cnt) begin
            bad++;
            $display("FAIL completion: cycle=%0d err=%b cnt=%0d required cycle=%0d err=%b cnt=%0d",
                     cyc, err, err_cnt, x.at, x.e, x.cnt);
          end
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_set_pass();
    issue(2'b10, 1'b1, 1'b0);
    for (int i = 0; i < PW; i++) begin
      total++;
      if (s !== 1'b1 || r !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL set_pulse: s=%b r=%b busy=%b required 1 0 1", s, r, busy);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < GW; i++) begin
      total++;
      if (s !== 1'b0 || r !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL set_gap: s=%b r=%b busy=%b done=%b required 0 0 1 0", s, r, busy, done);
      end
      @(posedge clk); #1;
    end
    total++;
    if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL set_done: done=%b err=%b ready=%b required 1 0 1", done, err, cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_fail();
    issue(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < PW; i++) begin
      total++;
      if (r !== 1'b1 || s !== 1'b0) begin
        bad++; $display("FAIL rst_pulse: s=%b r=%b required 0 1", s, r);
      end
      @(posedge clk); #1;
    end
    repeat (GW) begin @(posedge clk); #1; end
    total++;
    if (done !== 1'b1 || err !== 1'b1 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL rst_fail: done=%b err=%b cnt=%0d required 1 1 1", done, err, err_cnt);
    end
    issue(2'b01, 1'b0, 1'b1);
    repeat (LAT + 1) begin @(posedge clk); #1; end
    issue(2'b10, 1'b1, 1'b1);
    repeat (LAT + 1) begin @(posedge clk); #1; end
    issue(2'b10, 1'bx, 1'b0);
    repeat (LAT + 1) begin @(posedge clk); #1; end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(2'b11, 1'b0, 1'b1);
    total++;
    if (done !== 1'b1 || err !== 1'b1 || s !== 1'b0 || r !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_op: done=%b err=%b s=%b r=%b ready=%b required 1 1 0 0 1",
                      done, err, s, r, cmd_ready);
    end
    issue(2'b00, 1'b0, 1'b1);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || s !== 1'b0 || r !== 1'b0 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL hold_op: done=%b err=%b s=%b r=%b cnt=%0d required 1 0 0 0 1",
                      done, err, s, r, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      issue(2'b11, 1'b0, 1'b1);
      if (i == 255) begin
        total++;
        if (err_cnt !== 8'd255) begin
          bad++; $display("FAIL sat_255: cnt=%0d required 255", err_cnt);
        end
      end
    end
    total++;
    if (err !== 1'b1 || err_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_256: err=%b cnt=%0d required 1 255", err, err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    do_reset();
    issue(2'b10, 1'b1, 1'b0);
    @(posedge clk); #1;
    total++;
    if (s !== 1'b1) begin
      bad++; $display("FAIL mid_pulse: s=%b required 1", s);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (s !== 1'b0 || r !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL mid_reset: s=%b r=%b busy=%b done=%b err=%b required 0 0 0 0 0",
                      s, r, busy, done, err);
    end
    if (sb.size() > 0) begin
      void'(sb.pop_back());
      accepts--;
    end
    exp_cnt = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL mid_release: ready=%b required 1", cmd_ready);
    end
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic test_random();
    logic q, qb;
    do_reset();
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cmd_op = 2'($urandom_range(0, 3));
      if (cmd_ready === 1'b1) begin
        q  = 1'($urandom_range(0, 1));
        qb = ($urandom_range(0, 3) == 0) ? q : ~q;
        q_fb = q; qbar_fb = qb;
        push(cmd_op, q, qb);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    repeat (LAT + 4) begin @(posedge clk); #1; end
    total++;
    if (sb.size() != 0 || accepts != dones) begin
      bad++; $display("FAIL random_drain: pending=%0d dones=%0d required 0 pending dones=%0d",
                      sb.size(), dones, accepts);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_set_pass();
    test_reset_fail();
    test_back_to_back();
    test_saturate();
    test_rst_mid();
    test_random();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL final_drain: pending=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
